// File: rtl/stream_mac.sv
// stream_mac: signed multiply-accumulate over i_len-beat vectors, one result beat per vector.
// Optional feature macro: STREAM_MAC_SATURATE_EN (clamp the accumulator instead of wrapping).
module stream_mac #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int IN_WIDTH  = A_WIDTH + B_WIDTH,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [ACC_WIDTH-1:0] o_data,
  output logic                 o_dbg_active
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  // Handshake: a beat transfers on a rising edge where valid && ready are both 1;
  // valid never waits for ready, and ready may depend combinationally on the output side.

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                    r_state;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic                      r_p_valid;
  logic                      r_p_first;
  logic                      r_p_last;
  logic signed [P_WIDTH-1:0] r_p;
  logic [ACC_WIDTH-1:0]      r_acc;
  logic                      r_o_valid;
  logic [ACC_WIDTH-1:0]      r_o_data;

  logic                        w_en;
  logic                        w_accept;
  logic signed [A_WIDTH-1:0]   w_a;
  logic signed [B_WIDTH-1:0]   w_b;
  logic signed [P_WIDTH-1:0]   w_prod;
  logic [LEN_WIDTH-1:0]        w_len_eff;
  logic                        w_first;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_pe;
  logic signed [ACC_WIDTH-1:0] w_acc_base;
  logic [ACC_WIDTH-1:0]        w_acc_next;

  assign w_en     = !r_o_valid || o_ready;
  assign i_ready  = reset && w_en;
  assign w_accept = i_valid && i_ready;

  assign w_a    = i_data[IN_WIDTH-1:B_WIDTH];
  assign w_b    = i_data[B_WIDTH-1:0];
  assign w_prod = P_WIDTH'(w_a) * P_WIDTH'(w_b);

  // A zero length is an ordinary single-beat vector.
  assign w_len_eff = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
  assign w_first   = (r_state == S_IDLE);
  assign w_last    = w_first ? (w_len_eff == LEN_WIDTH'(1))
                             : (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_remaining <= w_len_eff - LEN_WIDTH'(1);
        r_state     <= (w_len_eff == LEN_WIDTH'(1)) ? S_IDLE : S_ACTIVE;
      end else begin
        r_remaining <= r_remaining - LEN_WIDTH'(1);
        if (r_remaining == LEN_WIDTH'(1)) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_p       <= '0;
    end else if (w_en) begin
      r_p_valid <= w_accept;
      r_p_first <= w_first;
      r_p_last  <= w_last;
      r_p       <= w_prod;
    end
  end

  assign w_pe       = ACC_WIDTH'(r_p);
  assign w_acc_base = r_p_first ? '0 : $signed(r_acc);

`ifdef STREAM_MAC_SATURATE_EN
  logic signed [ACC_WIDTH:0] w_sum;

  assign w_sum = (ACC_WIDTH+1)'(w_acc_base) + (ACC_WIDTH+1)'(w_pe);

  // The two top bits disagree exactly when the sum left the ACC_WIDTH range.
  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_acc_next = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_acc_next = w_acc_base + w_pe;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else if (w_en) begin
      if (r_p_valid) begin
        r_acc <= w_acc_next;
      end
      // w_en guarantees any held result has been taken, so clearing is safe.
      if (r_p_valid && r_p_last) begin
        r_o_data  <= w_acc_next;
        r_o_valid <= 1'b1;
      end else begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign o_valid      = r_o_valid;
  assign o_data       = r_o_data;
  assign o_dbg_active = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_stream_mac.sv
// Bench for stream_mac: directed tables, hand-timed corner sequences and randomized vectors
// scored against a plain-arithmetic dot-product model.
module tb_stream_mac;

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [31:0]      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_len;
  logic        i_valid;
  logic        i_ready, i_ready16;
  logic [15:0] i_data;
  logic        o_valid, o_valid16;
  logic        o_ready;
  logic [31:0] o_data;
  logic [15:0] o_data16;
  logic        dbg_active, dbg_active16;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  int          stall_waits = 0;
  logic [31:0] exp_q[$];
  bit          use_model = 0;
  bit          rnd_done = 0;

  int          m_cnt = 0;
  int          m_len = 0;
  logic [31:0] m_sum = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = 0;

  vec_t        tbl[6];

  stream_mac dut (
    .clk(clk), .reset(reset), .i_len(i_len), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_dbg_active(dbg_active)
  );

  stream_mac #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .i_len(i_len), .i_valid(i_valid), .i_ready(i_ready16),
    .i_data(i_data), .o_valid(o_valid16), .o_ready(o_ready), .o_data(o_data16),
    .o_dbg_active(dbg_active16)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: dot product of each group of effective-length beats
  function automatic void model_beat(input logic [7:0] len, input logic signed [7:0] a,
                                     input logic signed [7:0] b);
    if (m_cnt == 0) begin
      m_len = (len == 8'd0) ? 1 : int'(len);
      m_sum = 32'd0;
    end
    m_sum = m_sum + 32'(int'(a) * int'(b));
    m_cnt++;
    if (m_cnt == m_len) begin
      exp_q.push_back(m_sum);
      m_cnt = 0;
    end
  endfunction

  function automatic vec_t mk(input int len, input int n, input int a0, input int b0,
                              input int a1, input int b1, input int a2, input int b2,
                              input int a3, input int b3, input int exp);
    vec_t v;
    v.len = 8'(len);
    v.n   = 3'(n);
    v.a   = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.b   = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    v.exp = 32'(exp);
    return v;
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
      m_cnt      = 0;
    end else begin
      if (i_valid && i_ready && use_model) model_beat(i_len, i_data[15:8], i_data[7:0]);
      if (prev_stall) begin
        check("stall_valid_hold", {31'd0, o_valid}, 32'd1);
        check("stall_data_hold", o_data, prev_data);
      end
      if (o_valid && !o_ready) check("stall_i_ready", {31'd0, i_ready}, 32'd0);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got 0x%08h required none (t=%0t)", o_data, $time);
        end else begin
          check("result", o_data, exp_q.pop_front());
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
    end
  end

  // driver: offer one beat, hold until handshaked; returns at posedge+1
  task automatic send_beat(input logic [7:0] len, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    int n;
    i_len   = len;
    i_data  = {a, b};
    i_valid = 1'b1;
    ok = 0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = i_ready;
      if (ok) last_hs_cyc = cyc;
      else stall_waits++;
      @(posedge clk);
      n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_len   = 8'd0;
    i_data  = 16'd0;
    o_ready = 1'b1;

    tbl[0] = mk(3, 3,    1,    2,   3,    4,  5,  6,  0,  0, 44);
    tbl[1] = mk(2, 2,   -3,    4, 127, -128,  0,  0,  0,  0, -16268);
    tbl[2] = mk(0, 1,    5,   -7,   0,    0,  0,  0,  0,  0, -35);
    tbl[3] = mk(1, 1, -128, -128,   0,    0,  0,  0,  0,  0, 16384);
    tbl[4] = mk(4, 4, -128,  127, -128, 127, -128, 127, -128, 127, -65024);
    tbl[5] = mk(4, 4,   10,  -10,  20,   20, -5,  3,  0, 99, 285);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_o_valid", {31'd0, o_valid}, 32'd0);
    check("reset_o_data", o_data, 32'd0);
    check("reset_i_ready", {31'd0, i_ready}, 32'd0);
    check("reset_o_valid16", {31'd0, o_valid16}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, i_ready}, 32'd1);
    @(posedge clk);
    #1;

    // basic vector: latency and single-cycle valid
    exp_q.push_back(32'd44);
    send_beat(8'd3, 8'd1, 8'd2);
    send_beat(8'hA5, 8'd3, 8'd4);
    send_beat(8'hA5, 8'd5, 8'd6);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_valid && n < 20);
      check("basic_latency", 32'(cyc - last_hs_cyc), 32'd2);
      check("basic_data", o_data, 32'd44);
      @(negedge clk);
      check("basic_one_cycle", {31'd0, o_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // back-to-back length-1 vectors
    stall_waits = 0;
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd1);
    fork
      begin
        send_beat(8'd1, 8'd2, 8'd3);
        send_beat(8'd1, 8'd4, 8'd5);
        send_beat(8'd1, 8'hFF, 8'hFF);
      end
      begin
        int n, cnt;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!o_valid && n < 20);
        cnt = o_valid ? 1 : 0;
        repeat (2) begin
          @(negedge clk);
          if (o_valid) cnt++;
        end
        check("len1_consecutive", 32'(cnt), 32'd3);
      end
    join
    check("len1_no_ready_drop", 32'(stall_waits), 32'd0);
    wait_drain(50);

    // table-driven vectors, i_len garbage on non-first beats
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(tbl[v].exp);
      for (int j = 0; j < int'(tbl[v].n); j++) begin
        send_beat((j == 0) ? tbl[v].len : 8'hA5, tbl[v].a[j], tbl[v].b[j]);
      end
    end
    wait_drain(100);

    // backpressure
    exp_q.push_back(32'd44);
    exp_q.push_back(32'd5);
    o_ready = 1'b0;
    fork
      begin
        send_beat(8'd3, 8'd1, 8'd2);
        send_beat(8'hA5, 8'd3, 8'd4);
        send_beat(8'hA5, 8'd5, 8'd6);
        send_beat(8'd2, 8'd1, 8'd1);
        send_beat(8'hA5, 8'd2, 8'd2);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!o_valid && n < 50);
        check("bp_first_data", o_data, 32'd44);
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", {31'd0, o_valid}, 32'd1);
          check("bp_data", o_data, 32'd44);
          check("bp_i_ready", {31'd0, i_ready}, 32'd0);
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_i_ready", {31'd0, i_ready}, 32'd1);
      end
    join
    wait_drain(50);

    // reset mid-vector
    send_beat(8'd3, 8'd1, 8'd2);
    send_beat(8'hA5, 8'd3, 8'd4);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_o_data", o_data, 32'd0);
    check("midrst_i_ready", {31'd0, i_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'd49);
    send_beat(8'd1, 8'd7, 8'd7);
    wait_drain(50);

    // overflow on the 16-bit accumulator instance
    exp_q.push_back(32'd64516);
    fork
      begin
        for (int j = 0; j < 4; j++) send_beat((j == 0) ? 8'd4 : 8'hA5, 8'd127, 8'd127);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!o_valid16 && n < 40);
        check("ovf16_valid", {31'd0, o_valid16}, 32'd1);
`ifdef STREAM_MAC_SATURATE_EN
        check("ovf16_data", {16'd0, o_data16}, 32'h0000_7FFF);
`else
        check("ovf16_data", {16'd0, o_data16}, 32'h0000_FC04);
`endif
      end
    join
    wait_drain(50);

    // randomized vectors with random downstream stalls
    use_model = 1;
    rnd_done  = 0;
    fork
      begin
        for (int v = 0; v < 60; v++) begin
          int len, eff;
          len = $urandom_range(0, 5);
          eff = (len == 0) ? 1 : len;
          for (int j = 0; j < eff; j++) begin
            send_beat((j == 0) ? 8'(len) : 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          if (!rnd_done) o_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    o_ready = 1'b1;
    wait_drain(200);
    use_model = 0;
    check("model_no_partial", 32'(m_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
